// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock parametrised FIFO with registered storage, fill count,
//   almost-full/almost-empty thresholds, sticky overflow/underflow flags and
//   a selectable read mode (FWFT=0 registered read, FWFT=1 fall-through).
//
// Ports
//   clk           clock, all state updates on rising edge
//   reset_L       synchronous active-low reset
//   push, wdata   write request and data
//   pop           read request
//   rdata, rvalid read data and its valid qualifier
//   full, almost_full, empty, almost_empty   occupancy flags
//   count         occupancy 0..DEPTH (PTRWIDTH+1 bits)
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
//   clr_err       clears overflow/underflow (a coincident set wins)
module sync_fifo_param #(
  parameter int DEPTH     = 16,
  parameter int PTRWIDTH  = 4,
  parameter int DWIDTH    = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                push,
  input  logic [DWIDTH-1:0]   wdata,
  output logic                full,
  output logic                almost_full,
  input  logic                pop,
  output logic [DWIDTH-1:0]   rdata,
  output logic                rvalid,
  output logic                empty,
  output logic                almost_empty,
  output logic [PTRWIDTH:0]   count,
  output logic                overflow,
  output logic                underflow,
  input  logic                clr_err
);

  localparam logic [PTRWIDTH:0] LP_DEPTH  = (PTRWIDTH+1)'(DEPTH);
  localparam logic [PTRWIDTH:0] LP_AFULL  = (PTRWIDTH+1)'(AFULL_TH);
  localparam logic [PTRWIDTH:0] LP_AEMPTY = (PTRWIDTH+1)'(AEMPTY_TH);

  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic [PTRWIDTH:0]   r_wrptr;
  logic [PTRWIDTH:0]   r_rdptr;
  logic                r_overflow;
  logic                r_underflow;

  logic [PTRWIDTH:0]   w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_push_ok;
  logic                w_pop_ok;
  logic [PTRWIDTH-1:0] w_rdidx;
  logic [PTRWIDTH-1:0] w_wridx;

  // Extra wrap bit makes full (difference == DEPTH) distinct from empty.
  assign w_count   = r_wrptr - r_rdptr;
  assign w_full    = (w_count == LP_DEPTH);
  assign w_empty   = (w_count == '0);
  assign w_push_ok = push && !w_full;
  assign w_pop_ok  = pop && !w_empty;
  assign w_rdidx   = r_rdptr[PTRWIDTH-1:0];
  assign w_wridx   = r_wrptr[PTRWIDTH-1:0];

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= LP_AFULL);
  assign almost_empty = (w_count <= LP_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_wrptr     <= '0;
      r_rdptr     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wrptr <= r_wrptr + 1'b1;
      if (w_pop_ok)  r_rdptr <= r_rdptr + 1'b1;

      if (push && w_full)     r_overflow <= 1'b1;
      else if (clr_err)       r_overflow <= 1'b0;

      if (pop && w_empty)     r_underflow <= 1'b1;
      else if (clr_err)       r_underflow <= 1'b0;
    end
  end

  // Storage is not reset; a push coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    if (reset_L && w_push_ok) r_mem[w_wridx] <= wdata;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DWIDTH-1:0] r_rdata;
      logic              r_rvalid;

      always_ff @(posedge clk) begin
        if (!reset_L) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_pop_ok;
          if (w_pop_ok) r_rdata <= r_mem[w_rdidx];
        end
      end

      assign rdata  = r_rdata;
      assign rvalid = r_rvalid;
    end else begin : g_fwft_read
      // Head word shown directly; forced to zero while empty so stale
      // storage never leaks out (and rdata reads 0 after reset).
      assign rdata  = w_empty ? '0 : r_mem[w_rdidx];
      assign rvalid = !w_empty;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the next-generation buffer for same-domain datapaths and replaces ad-hoc combinational memory writes with fully registered storage. Adds fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable read mode (standard registered read or first-word-fall-through). Sits between a producer and consumer in one clock domain. Binary pointers carry one extra wrap bit.

Parameters:
DEPTH, 16, number of entries; must equal 2**PTRWIDTH
PTRWIDTH, 4, address width; pointers and count are PTRWIDTH+1 bits
DWIDTH, 8, data word width
FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
AFULL_TH, 12, almost_full asserted when count >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset_L  input  1  reset is synchronous and active-low
push  input  1  write request
wdata  input  DWIDTH  write data
full  output  1  count == DEPTH
almost_full  output  1  count >= AFULL_TH
pop  input  1  read request
rdata  output  DWIDTH  read data
rvalid  output  1  rdata valid qualifier
empty  output  1  count == 0
almost_empty  output  1  count <= AEMPTY_TH
count  output  PTRWIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty
clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset (reset_L=0 at clk edge): wrptr=rdptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rdata=0, rvalid=0, overflow=0, underflow=0. Memory contents are not cleared. Reset mid-operation discards all stored words. Reset has priority over all other inputs.
- Accept rules use the flags registered before the edge:
  - Push is accepted iff push && !full. The accepted push writes mem[wrptr[PTRWIDTH-1:0]] and increments wrptr.
  - Pop is accepted iff pop && !empty. The accepted pop increments rdptr.
- Pointers are PTRWIDTH+1 bits and wrap naturally mod 2*DEPTH. count = wrptr - rdptr (mod 2**(PTRWIDTH+1)).
- count, full, empty, almost_full and almost_empty all reflect the state after the edge. One accepted push gives count+1. One accepted pop gives count-1.
- Simultaneous accepted push and pop leaves count unchanged; both pointers advance.
- Push while full is dropped: no memory write, pointers unchanged, overflow set. This holds even if a pop is accepted the same cycle.
- Pop while empty is rejected: rdptr unchanged, underflow set. This holds even if a push is accepted the same cycle.
- overflow/underflow clear when clr_err=1. If a set and clr_err coincide, set wins.
- FWFT=0 read path:
  - An accepted pop loads rdata <= mem[rdptr] at that edge. rvalid=1 for exactly the following cycle.
  - rdata holds its last value otherwise.
  - Latency: pop at edge N gives data valid after edge N.
- FWFT=1 read path:
  - rdata = mem[rdptr] continuously, rvalid = !empty.
  - A push into an empty FIFO at edge N deasserts empty and presents the word after edge N.
  - pop consumes the head; the next word (if any) appears after the edge.
- Write and read of the same address in one cycle is legal only when count>0 and the read returns the old word. The full/pop-only rules prevent collision with unread data.

Test Plan:
- Reset, then push 0x01..0x10 on consecutive cycles -> almost_full rises after the 12th push; full=1 and count=16 after the 16th; empty=0 after the 1st push.
- At full, push 0xAA -> overflow=1, count stays 16. Pop all 16 (FWFT=0) -> rdata sequence 0x01..0x10, each with a one-cycle rvalid, no 0xAA. Then empty=1 and almost_empty=1 once count<=4.
- Pop while empty -> underflow=1, rvalid stays 0, count=0. clr_err pulse -> overflow=underflow=0. Set and clr_err coinciding -> flag stays 1.
- Hold count=5, drive push+pop together for 40 cycles with incrementing data -> count stays 5, pointers wrap past 31, output order is preserved.
- FWFT=1: push 0x5C into empty -> next cycle rdata=0x5C, rvalid=1 with no pop. Pop -> empty=1, rvalid=0.
- Push 6 words, assert reset_L=0 for one cycle during a push -> count=0, empty=1, full=0, rdata=0, flags=0. The next push/pop returns only the new data.
